// File: rtl/hit_detect_if.sv
// Bullet-table bus between the hit detector and the bullet table.
//
// The detector is the master: it drives the read address and the delete
// strobe. The table is the slave: it answers each read address with
// bullet_valid/bullet_x/bullet_y on the following cycle.
//
// Signals
//   bullet_rd_addr   master->slave  table read address
//   bullet_valid     slave->master  entry holds a live bullet
//   bullet_x/y       slave->master  bullet position in screen pixels
//   bullet_clr       master->slave  one-cycle delete strobe
//   bullet_clr_addr  master->slave  index deleted by bullet_clr
interface hit_detect_if #(
    parameter int NUM_BULLETS = 16
);
    localparam int AW = $clog2(NUM_BULLETS);

    logic [AW-1:0] bullet_rd_addr;
    logic          bullet_valid;
    logic [9:0]    bullet_x;
    logic [9:0]    bullet_y;
    logic          bullet_clr;
    logic [AW-1:0] bullet_clr_addr;

    modport master (
        output bullet_rd_addr,
        output bullet_clr,
        output bullet_clr_addr,
        input  bullet_valid,
        input  bullet_x,
        input  bullet_y
    );

    modport slave (
        input  bullet_rd_addr,
        input  bullet_clr,
        input  bullet_clr_addr,
        output bullet_valid,
        output bullet_x,
        output bullet_y
    );
endinterface

// File: rtl/hit_detect.sv
// Player/bullet collision detector.
//
// Once per video frame the bullet table is walked from index 0 upwards and
// every live bullet is tested against a square hitbox around the player.
// The first overlapping bullet is deleted from the table, is_hit is raised
// for HOLD_CYCLES cycles so the health counter samples it exactly once per
// sampling period, and the player becomes invulnerable for IFRAMES frames.
// While invulnerable, frame ticks only count the invulnerability down.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   player_x/y        player centre (latched when a scan starts)
//   bus               bullet-table master port (read address, read data,
//                     delete strobe/address)
//   is_hit            hit level, high HOLD_CYCLES cycles per hit
//   invuln            high while invulnerability frames remain
//   busy              high while scanning or clearing
module hit_detect #(
    parameter int NUM_BULLETS = 16,
    parameter int HIT_R       = 4,
    parameter int HOLD_CYCLES = 1000002,
    parameter int IFRAMES     = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic [9:0]          player_x,
    input  logic [9:0]          player_y,
    hit_detect_if.master        bus,
    output logic                is_hit,
    output logic                invuln,
    output logic                busy
);

    localparam int AW = $clog2(NUM_BULLETS);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int IW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BULLETS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_reg,      state_next;
    logic [AW-1:0]    addr_reg,       addr_next;
    // issuing: an address is still being presented this cycle.
    logic             issuing_reg,    issuing_next;
    // cmp_valid/cmp_idx: table data on the bus this cycle belongs to the
    // address presented one cycle earlier.
    logic             cmp_valid_reg,  cmp_valid_next;
    logic [AW-1:0]    cmp_idx_reg,    cmp_idx_next;
    logic             clr_reg,        clr_next;
    logic [AW-1:0]    clr_addr_reg,   clr_addr_next;
    logic [HW-1:0]    hold_cnt_reg,   hold_cnt_next;
    logic [IW-1:0]    inv_cnt_reg,    inv_cnt_next;
    // Index 0 is x, index 1 is y; both axes share the same comparator.
    logic [1:0][9:0]  player_pos_reg, player_pos_next;

    // ------------------------------------------------------------------
    // Hitbox test, one comparator per axis
    // ------------------------------------------------------------------
    logic [1:0][9:0]  bullet_pos;
    logic [1:0]       axis_near;
    logic             bullet_hit;

    assign bullet_pos = {bus.bullet_y, bus.bullet_x};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [10:0] diff;
            logic        [10:0] mag;

            // Zero-extend before subtracting so screen edges never wrap:
            // 0 and 1023 are 1023 apart, not 1.
            assign diff = $signed({1'b0, bullet_pos[gi]}) - $signed({1'b0, player_pos_reg[gi]});
            assign mag  = diff[10] ? 11'(-diff) : 11'(diff);
            assign axis_near[gi] = (mag <= 11'(HIT_R));
        end
    endgenerate

    assign bullet_hit = bus.bullet_valid & (&axis_near);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        issuing_next    = issuing_reg;
        cmp_valid_next  = 1'b0;
        cmp_idx_next    = cmp_idx_reg;
        clr_next        = 1'b0;
        clr_addr_next   = clr_addr_reg;
        player_pos_next = player_pos_reg;
        inv_cnt_next    = inv_cnt_reg;
        hold_cnt_next   = (hold_cnt_reg != '0) ? hold_cnt_reg - HW'(1) : hold_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                issuing_next = 1'b0;
                if (frame_tick) begin
                    if (inv_cnt_reg == '0) begin
                        state_next      = ST_SCAN;
                        addr_next       = '0;
                        issuing_next    = 1'b1;
                        player_pos_next = {player_y, player_x};
                    end else begin
                        inv_cnt_next = inv_cnt_reg - IW'(1);
                    end
                end
            end

            ST_SCAN: begin
                // Address pipeline: the entry read now is compared next cycle.
                cmp_valid_next = issuing_reg;
                cmp_idx_next   = addr_reg;
                if (issuing_reg) begin
                    if (addr_reg == LAST_IDX) begin
                        issuing_next = 1'b0;
                    end else begin
                        addr_next = addr_reg + AW'(1);
                    end
                end

                if (cmp_valid_reg && bullet_hit) begin
                    // First hit wins; the in-flight read is discarded and the
                    // address freezes so later entries are never looked at.
                    state_next     = ST_CLEAR;
                    addr_next      = addr_reg;
                    issuing_next   = 1'b0;
                    cmp_valid_next = 1'b0;
                    clr_next       = 1'b1;
                    clr_addr_next  = cmp_idx_reg;
                    hold_cnt_next  = HW'(HOLD_CYCLES);
                    inv_cnt_next   = IW'(IFRAMES);
                end else if (cmp_valid_reg && (cmp_idx_reg == LAST_IDX)) begin
                    state_next     = ST_IDLE;
                    cmp_valid_next = 1'b0;
                end
            end

            ST_CLEAR: begin
                // The delete strobe and hit level are already on the outputs;
                // frame ticks arriving here are simply ignored.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            issuing_reg    <= 1'b0;
            cmp_valid_reg  <= 1'b0;
            cmp_idx_reg    <= '0;
            clr_reg        <= 1'b0;
            clr_addr_reg   <= '0;
            hold_cnt_reg   <= '0;
            inv_cnt_reg    <= '0;
            player_pos_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            issuing_reg    <= issuing_next;
            cmp_valid_reg  <= cmp_valid_next;
            cmp_idx_reg    <= cmp_idx_next;
            clr_reg        <= clr_next;
            clr_addr_reg   <= clr_addr_next;
            hold_cnt_reg   <= hold_cnt_next;
            inv_cnt_reg    <= inv_cnt_next;
            player_pos_reg <= player_pos_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.bullet_rd_addr  = addr_reg;
    assign bus.bullet_clr      = clr_reg;
    assign bus.bullet_clr_addr = clr_addr_reg;
    assign is_hit              = (hold_cnt_reg != '0);
    assign invuln              = (inv_cnt_reg != '0);
    assign busy                = (state_reg != ST_IDLE);

endmodule

// File: doc/hit_detect.md
HIT_DETECT -- requirements
Module: hit_detect

Interface
REQ-001 Parameter NUM_BULLETS, default 16, number of bullet-table entries scanned per frame (power of two, 2..64).
REQ-002 Parameter HIT_R, default 4, hitbox half-size in pixels, applied to both axes.
REQ-003 Parameter HOLD_CYCLES, default 1000002, number of cycles is_hit stays high per hit; this covers one full health-sampling period.
REQ-004 Parameter IFRAMES, default 60, number of invulnerability frames after a hit.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 player_x, player_y  in  10 each  player centre in screen pixels.
REQ-009 bullet_rd_addr  out  log2(NUM_BULLETS)  bullet-table read address.
REQ-010 bullet_valid, bullet_x[9:0], bullet_y[9:0]  in  1/10/10  table read data, valid exactly one cycle after bullet_rd_addr.
REQ-011 bullet_clr  out  1  one-cycle pulse that deletes entry bullet_clr_addr.
REQ-012 bullet_clr_addr  out  log2(NUM_BULLETS)  index of the bullet to delete.
REQ-013 is_hit  out  1  hit level, consumed by the health counter.
REQ-014 invuln  out  1  high while invulnerability frames remain.
REQ-015 busy  out  1  high while in SCAN or CLEAR.

Function
REQ-016 FSM states: IDLE, SCAN, CLEAR.
REQ-017 IDLE->SCAN on frame_tick with invuln=0: latch player_x/player_y, set the scan index to 0.
REQ-018 frame_tick with invuln=1 shall not start a scan; it decrements the invulnerability counter by 1.
REQ-019 In SCAN, bullet_rd_addr steps 0..NUM_BULLETS-1, one per cycle; the entry at index k is compared one cycle after its address.
REQ-020 Hit condition: bullet_valid=1 and |bullet_x-player_x|<=HIT_R and |bullet_y-player_y|<=HIT_R.
REQ-021 Differences are computed as 11-bit signed values with no wrap-around; coordinates 0 and 1023 are 1023 apart.
REQ-022 First hit at index k: stop issuing addresses, record k, go to CLEAR; higher-index hits in the same frame are ignored.
REQ-023 No hit after index NUM_BULLETS-1 is compared: SCAN->IDLE.
REQ-024 CLEAR lasts one cycle:
- bullet_clr=1 and bullet_clr_addr=k;
- is_hit rises;
- hold counter loads HOLD_CYCLES;
- invulnerability counter loads IFRAMES;
- next state is IDLE.
REQ-025 is_hit stays high for exactly HOLD_CYCLES cycles, counted from the CLEAR cycle inclusive.
REQ-026 invuln=1 whenever the invulnerability counter is nonzero.
REQ-027 Latency: frame_tick at cycle T gives address k at T+1+k and compares entry k at T+2+k. A hit on k puts CLEAR at T+3+k. With no hit the FSM returns to IDLE at T+2+NUM_BULLETS.
REQ-028 frame_tick arriving during SCAN or CLEAR is dropped (not queued) and does not touch the invulnerability counter.
REQ-029 bullet_rd_addr holds its last value while in IDLE.

Reset
REQ-030 rst forces the FSM to IDLE from any state, including mid-SCAN and mid-hold.
REQ-031 rst clears is_hit, invuln, busy, bullet_clr, bullet_rd_addr, bullet_clr_addr, the hold counter and the invulnerability counter to 0.
REQ-032 The first frame_tick after rst is released starts a scan.

Verification
REQ-033 Player (100,100), entry 3 valid at (104,96), all others invalid, frame_tick at T -> bullet_clr at T+6 with addr=3, is_hit high HOLD_CYCLES cycles, invuln=1.
REQ-034 Player (100,100), entry 0 at (105,100) -> no hit; busy falls and the FSM reaches IDLE at T+2+NUM_BULLETS; is_hit=0.
REQ-035 Entries 2 and 7 both overlapping -> single bullet_clr with addr=2 only.
REQ-036 After a hit, overlapping bullet present for 60 frame_ticks -> no scan and no bullet_clr; the 61st frame_tick scans and hits again.
REQ-037 Player (0,0), bullet (1023,0) valid -> no hit.
REQ-038 rst asserted at cycle T+4 mid-scan -> next cycle all outputs 0, state IDLE; next frame_tick scans normally from index 0.
